// File: rtl/pmem_arbiter.sv
// Two-port (instruction/data cache) arbiter in front of a single physical memory port.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed data-first priority for alternating priority.
`timescale 1ns/1ps

module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_write;

    logic w_reqI;
    logic w_reqD;
    logic w_pickD;

    assign w_reqI = i_read | i_write;
    assign w_reqD = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastGntD;

    // Pointer only moves on a contested grant, so an uncontested grant does not steal the next turn.
    assign w_pickD = w_reqD & (~w_reqI | ~r_lastGntD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGntD <= 1'b0;
        end else if (r_state == IDLE && w_reqI && w_reqD) begin
            r_lastGntD <= w_pickD;
        end
    end
`else
    assign w_pickD = w_reqD;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Write wins when a port raises read and write together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_pickD) begin
                r_addr  <= d_address;
                r_wdata <= d_wdata;
                r_write <= d_write;
            end else if (w_reqI) begin
                r_addr  <= i_address;
                r_wdata <= i_wdata;
                r_write <= i_write;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pickD) begin
                    w_nextState = GRANT_D;
                end else if (w_reqI) begin
                    w_nextState = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Memory side is fed only from the latched request; the requester may change its inputs freely.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;
        if (r_state == GRANT_I || r_state == GRANT_D) begin
            pmem_read    = ~r_write;
            pmem_write   = r_write;
            pmem_address = r_addr;
            pmem_wdata   = r_wdata;
        end
        if (r_state == GRANT_I && pmem_resp) begin
            i_resp  = 1'b1;
            i_rdata = pmem_rdata;
        end
        if (r_state == GRANT_D && pmem_resp) begin
            d_resp  = 1'b1;
            d_rdata = pmem_rdata;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of grant order and memory traffic.
`timescale 1ns/1ps

module tb_pmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_address, d_address;
    logic [LINE_W-1:0] i_wdata, d_wdata;
    logic              i_resp, d_resp;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    int checks   = 0;
    int failures = 0;
    bit lastWasD = 1'b0;

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand128();
        return LINE_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Reference arbitration: which port wins when the given ports are requesting.
    function automatic bit modelPickD(input bit reqI, input bit reqD);
        if (!reqD) return 1'b0;
        if (!reqI) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        begin
            bit pick;
            pick = !lastWasD;
            lastWasD = pick;
            return pick;
        end
`else
        return 1'b1;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkBit({tag, "_pmem_read"}, pmem_read, 1'b0);
        checkBit({tag, "_pmem_write"}, pmem_write, 1'b0);
        checkBit({tag, "_i_resp"}, i_resp, 1'b0);
        checkBit({tag, "_d_resp"}, d_resp, 1'b0);
        checkOutput({tag, "_i_rdata"}, i_rdata, '0);
        checkOutput({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    task automatic checkReset(input string tag);
        checkQuiet(tag);
        checkOutput({tag, "_pmem_address"}, LINE_W'(pmem_address), '0);
        checkOutput({tag, "_pmem_wdata"}, pmem_wdata, '0);
    endtask

    task automatic checkGrant(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [LINE_W-1:0] wd);
        checkBit({tag, "_pmem_read"}, pmem_read, !wr);
        checkBit({tag, "_pmem_write"}, pmem_write, wr);
        checkOutput({tag, "_pmem_address"}, LINE_W'(pmem_address), LINE_W'(addr));
        checkOutput({tag, "_pmem_wdata"}, pmem_wdata, wd);
    endtask

    // port: 0 = instruction, 1 = data, 2 = nobody responds this cycle
    task automatic checkResp(input string tag, input int port, input logic [LINE_W-1:0] rd);
        checkBit({tag, "_i_resp"}, i_resp, port == 0);
        checkBit({tag, "_d_resp"}, d_resp, port == 1);
        checkOutput({tag, "_i_rdata"}, i_rdata, (port == 0) ? rd : '0);
        checkOutput({tag, "_d_rdata"}, d_rdata, (port == 1) ? rd : '0);
    endtask

    task automatic applyStimulus(input logic rI, input logic wI, input logic [ADDR_W-1:0] aI,
                                 input logic [LINE_W-1:0] wdI, input logic rD, input logic wD,
                                 input logic [ADDR_W-1:0] aD, input logic [LINE_W-1:0] wdD);
        i_read = rI; i_write = wI; i_address = aI; i_wdata = wdI;
        d_read = rD; d_write = wD; d_address = aD; d_wdata = wdD;
    endtask

    task automatic scramblePort(input int port);
        if (port == 0) begin
            i_read = 1'($urandom); i_write = 1'($urandom);
            i_address = ADDR_W'($urandom); i_wdata = rand128();
        end else begin
            d_read = 1'($urandom); d_write = 1'($urandom);
            d_address = ADDR_W'($urandom); d_wdata = rand128();
        end
    endtask

    task automatic dropPort(input int port);
        if (port == 0) begin
            i_read = 1'b0; i_write = 1'b0;
        end else begin
            d_read = 1'b0; d_write = 1'b0;
        end
    endtask

    // One arbitration round: both ports present their request in the same IDLE cycle,
    // the model predicts grant order, and each granted transaction is run to completion.
    task automatic runRound(input logic rdI, input logic wrI, input logic rdD, input logic wrD,
                            input logic [ADDR_W-1:0] aI, input logic [ADDR_W-1:0] aD,
                            input logic [LINE_W-1:0] wdI, input logic [LINE_W-1:0] wdD,
                            input logic [LINE_W-1:0] rdataI, input logic [LINE_W-1:0] rdataD,
                            input int latI, input int latD, input bit strayIdle);
        int order[$];
        bit reqI = rdI | wrI;
        bit reqD = rdD | wrD;
        logic exWr;
        logic [ADDR_W-1:0] exA;
        logic [LINE_W-1:0] exWd, exRd;
        int lat;
        if (modelPickD(reqI, reqD)) begin
            order.push_back(1);
            if (reqI) order.push_back(0);
        end else if (reqI) begin
            order.push_back(0);
            if (reqD) order.push_back(1);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        applyStimulus(rdI, wrI, aI, wdI, rdD, wrD, aD, wdD);
        @(negedge clk); checkQuiet("idle_req");
        foreach (order[n]) begin
            if (order[n] == 1) begin
                exWr = wrD; exA = aD; exWd = wdD; exRd = rdataD; lat = latD;
            end else begin
                exWr = wrI; exA = aI; exWd = wdI; exRd = rdataI; lat = latI;
            end
            @(posedge clk); #1;
            repeat (lat) begin
                scramblePort(order[n]);
                pmem_rdata = rand128();
                @(negedge clk);
                checkGrant("grant_hold", exWr, exA, exWd);
                checkResp("grant_wait", 2, '0);
                @(posedge clk); #1;
            end
            scramblePort(order[n]);
            pmem_resp = 1'b1;
            pmem_rdata = exRd;
            @(negedge clk);
            checkGrant("grant_resp", exWr, exA, exWd);
            checkResp("resp", order[n], exRd);
            @(posedge clk); #1;
            dropPort(order[n]);
            pmem_resp = 1'($urandom);
            pmem_rdata = rand128();
            @(negedge clk); checkQuiet("done");
            @(posedge clk); #1;
            pmem_resp = (n == order.size() - 1) ? strayIdle : 1'b0;
            @(negedge clk); checkQuiet("idle_after");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        pmem_rdata = rand128();
        applyStimulus(1'b1, 1'b1, 16'h1111, rand128(), 1'b1, 1'b0, 16'h2222, rand128());
        #2; checkReset("reset_hold");
        #9;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        #1; rst_n = 1'b1;

        $display("[TB] simultaneous read requests");
        runRound(1'b1, 1'b0, 1'b1, 1'b0, 16'h4560, 16'h1230, rand128(), rand128(),
                 rand128(), rand128(), 2, 2, 1'b0);
        runRound(1'b1, 1'b0, 1'b1, 1'b0, 16'h4560, 16'h1230, rand128(), rand128(),
                 rand128(), rand128(), 1, 0, 1'b0);

        $display("[TB] data write held across slow memory");
        runRound(1'b0, 1'b0, 1'b0, 1'b1, '0, 16'h00F0, '0, {16{8'hA5}},
                 '0, rand128(), 0, 5, 1'b1);

        $display("[TB] instruction read, response in third cycle");
        runRound(1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, '0, rand128(), '0,
                 {4{32'hDEADBEEF}}, '0, 1, 0, 1'b0);

        $display("[TB] read and write together on both ports");
        runRound(1'b1, 1'b1, 1'b1, 1'b1, 16'h7777, 16'h8888, rand128(), rand128(),
                 rand128(), rand128(), 0, 3, 1'b1);

        $display("[TB] reset during data grant");
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 16'h0BAD, {4{32'h01234567}});
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk); checkGrant("pre_reset", 1'b1, 16'h0BAD, {4{32'h01234567}});
        #1;
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        pmem_rdata = rand128();
        #1; checkReset("async_reset");
        @(posedge clk); #1; checkReset("reset_clocked");
        #2; rst_n = 1'b1;
        lastWasD = 1'b0;
        @(negedge clk); checkQuiet("stray_idle");
        @(posedge clk); #2; checkQuiet("stray_idle2");
        pmem_resp = 1'b0;
        runRound(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h3210, '0, rand128(),
                 '0, rand128(), 0, 1, 1'b0);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 40; r++) begin
            runRound(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     ADDR_W'($urandom), ADDR_W'($urandom), rand128(), rand128(),
                     rand128(), rand128(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                     1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
